// File: rtl/rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter_8
// Brief   : 8-way round-robin arbiter with registered grant, release and hold timeout.
// Revision: 1.0
// ============================================================================
module rr_arbiter_8 #(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] C_HOLD_LIMIT = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] C_HOLD_SAT   = '1;

    generate
        if ((2 ** HOLD_W) <= MAX_HOLD) begin : g_param_check
            $error("HOLD_W too narrow for MAX_HOLD");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [2:0]        last_q, last_d;
    logic [2:0]        idx_q, idx_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [7:0]        gnt_q, gnt_d;
    logic              to_q, to_d;

    logic              w_found;
    logic [2:0]        w_win;
    logic [2:0]        w_cand;
    logic              w_own_req;
    logic              w_at_limit;
    logic              w_release;

    // Scan last+1 .. last+8 (mod 8) so the previous owner is checked last.
    always_comb begin
        w_found = 1'b0;
        w_win   = last_q;
        w_cand  = last_q;
        for (int i = 1; i <= 8; i++) begin
            w_cand = last_q + 3'(i);
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    assign w_own_req  = req[idx_q];
    assign w_at_limit = (MAX_HOLD != 0) && (hold_q == C_HOLD_LIMIT);
    assign w_release  = done || !w_own_req || w_at_limit;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        hold_d  = hold_q;
        gnt_d   = gnt_q;
        to_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_found) begin
                    state_d = GRANT;
                    idx_d   = w_win;
                    gnt_d   = 8'(1) << w_win;
                    hold_d  = HOLD_W'(1);
                end
            end
            GRANT: begin
                if (w_release) begin
                    state_d = IDLE;
                    last_d  = idx_q;
                    gnt_d   = 8'b0;
                    hold_d  = '0;
                    // Only a pure timeout is flagged; a voluntary release wins.
                    to_d    = w_at_limit && !done && w_own_req;
                end else if (hold_q != C_HOLD_SAT) begin
                    hold_d  = hold_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 8'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 3'd7;
            idx_q   <= 3'd0;
            hold_q  <= '0;
            gnt_q   <= 8'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            hold_q  <= hold_d;
            gnt_q   <= gnt_d;
            to_q    <= to_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = (state_q == GRANT);
    assign timeout   = to_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_8.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_arbiter_8
// Brief   : Self-checking bench for rr_arbiter_8 (vector table, directed sequences, random vs. model).
// Revision: 1.0
// ============================================================================
module tb_rr_arbiter_8;

    localparam int MAX_HOLD = 4;
    localparam int HOLD_W   = 3;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: current owner (-1 = none), last owner, cycles held.
    int         m_owner;
    int         m_last;
    int         m_held;
    logic [2:0] m_idx;
    logic       m_to;

    typedef struct {
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } vec_t;

    vec_t tbl [20];

    rr_arbiter_8 #(
        .MAX_HOLD (MAX_HOLD),
        .HOLD_W   (HOLD_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 7;
        m_held  = 0;
        m_idx   = 3'd0;
        m_to    = 1'b0;
    endtask

    task automatic model_step();
        m_to = 1'b0;
        if (m_owner < 0) begin
            if (req != 8'b0) begin
                for (int k = 1; k <= 8; k++) begin
                    if (req[(m_last + k) % 8]) begin
                        m_owner = (m_last + k) % 8;
                        break;
                    end
                end
                m_idx  = 3'(m_owner);
                m_held = 1;
            end
        end else begin
            if (done || !req[m_owner] || m_held == MAX_HOLD) begin
                m_to    = !done && req[m_owner];
                m_last  = m_owner;
                m_owner = -1;
                m_held  = 0;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        eg = (m_owner >= 0) ? (8'(1) << m_owner) : 8'b0;
        chk({tag, ".gnt"},     32'(gnt),       32'(eg));
        chk({tag, ".idx"},     32'(gnt_idx),   32'(m_idx));
        chk({tag, ".valid"},   32'(gnt_valid), 32'(m_owner >= 0));
        chk({tag, ".timeout"}, 32'(timeout),   32'(m_to));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic sync_reset_pulse();
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        // req, done -> gnt, idx, valid, timeout (after the edge); MAX_HOLD = 4
        tbl[0]  = '{8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[3]  = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[4]  = '{8'h00, 1'b0, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[5]  = '{8'h21, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0};
        tbl[6]  = '{8'h21, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0};
        tbl[7]  = '{8'h20, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0};
        tbl[8]  = '{8'h20, 1'b1, 8'h00, 3'd5, 1'b0, 1'b0};
        tbl[9]  = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[10] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[11] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[12] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[13] = '{8'h08, 1'b0, 8'h00, 3'd3, 1'b0, 1'b1};
        tbl[14] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[15] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[16] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[17] = '{8'h08, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0};
        tbl[18] = '{8'h00, 1'b1, 8'h00, 3'd3, 1'b0, 1'b0};
        tbl[19] = '{8'h00, 1'b0, 8'h00, 3'd3, 1'b0, 1'b0};

        rst  = 1'b1;
        req  = 8'b0;
        done = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst.gnt",     32'(gnt),       32'h0);
        chk("rst.idx",     32'(gnt_idx),   32'h0);
        chk("rst.valid",   32'(gnt_valid), 32'h0);
        chk("rst.timeout", 32'(timeout),   32'h0);
        rst = 1'b0;

        // Directed vectors: basic grant, wrap past 6/7, timeout and late release.
        for (int v = 0; v < 20; v++) begin
            req  = tbl[v].req;
            done = tbl[v].done;
            tick($sformatf("vec%0d", v));
            chk($sformatf("vec%0d.tgnt", v),   32'(gnt),       32'(tbl[v].gnt));
            chk($sformatf("vec%0d.tidx", v),   32'(gnt_idx),   32'(tbl[v].idx));
            chk($sformatf("vec%0d.tvalid", v), 32'(gnt_valid), 32'(tbl[v].valid));
            chk($sformatf("vec%0d.tto", v),    32'(timeout),   32'(tbl[v].to));
        end

        // All requesting, done on the 3rd cycle of every grant: order 0..7,0.
        sync_reset_pulse();
        for (int g = 0; g < 9; g++) begin
            req  = 8'hFF;
            done = 1'b0;
            for (int c = 0; c < 3; c++) begin
                tick("rr");
                chk($sformatf("rr%0d.c%0d.gnt", g, c), 32'(gnt), 32'(8'(1) << (g % 8)));
            end
            done = 1'b1;
            tick("rr_rel");
            chk($sformatf("rr%0d.dead", g), 32'(gnt), 32'h0);
            done = 1'b0;
        end

        // Asynchronous reset in the middle of requester 6's grant.
        sync_reset_pulse();
        req = 8'h40;
        tick("ar_grant");
        chk("ar.gnt6", 32'(gnt), 32'h40);
        req = 8'hFF;
        tick("ar_hold");
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("ar.gnt_now",   32'(gnt),       32'h0);
        chk("ar.valid_now", 32'(gnt_valid), 32'h0);
        chk("ar.idx_now",   32'(gnt_idx),   32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick("ar_after");
        chk("ar.first_gnt", 32'(gnt), 32'h01);

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 9) == 0) r = 8'h00;
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            req  = r;
            done = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2;
                rst = 1'b1;
                model_reset();
                #1;
                check_model("rnd_rst");
                #1;
                rst = 1'b0;
            end
            tick("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- 8-requester round-robin arbiter for one shared resource.
- Produces a registered 3-bit grant index plus its 3-to-8 one-hot decode.
- Grant is held until the owner releases it or a hold timeout expires.
- Sits in front of any 8-way shared block (bus, memory port) and sequences access to it.

Parameters:
- MAX_HOLD, 16, maximum cycles one grant may last; 0 disables the timeout.
- HOLD_W, 5, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  8  request vector; bit n = requester n
- done  input  1  owner release strobe; valid only while gnt_valid=1
- gnt  output  8  one-hot grant; equals decode(gnt_idx) when gnt_valid=1, else 8'b0
- gnt_idx  output  3  binary index of the current owner
- gnt_valid  output  1  a grant is active
- timeout  output  1  1-cycle pulse when a grant is forcibly revoked

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst. All outputs and state are registered.
- Reset values:
  - gnt=8'b0, gnt_idx=3'd0, gnt_valid=0, timeout=0.
  - state=IDLE, hold_cnt=0.
  - last pointer=3'd7, so requester 0 has first priority after reset.
- States: IDLE, GRANT.
- IDLE:
  - If req=0, stay in IDLE with outputs 0.
  - Otherwise choose the first set bit scanning last+1, last+2, … with wrap 7→0.
  - Next edge: gnt_idx=winner, gnt_valid=1, gnt=one-hot(winner), hold_cnt=1, go to GRANT.
  - Latency is 1 cycle from req sampled to gnt high.
- GRANT: the grant is released at the edge where any of these holds:
  - (a) done=1;
  - (b) req[gnt_idx]=0;
  - (c) MAX_HOLD≠0 and hold_cnt==MAX_HOLD, meaning the grant has been visible for MAX_HOLD cycles.
- On release:
  - last=gnt_idx, gnt_valid=0, gnt=0, hold_cnt=0, go to IDLE.
  - gnt_idx keeps its old value.
  - timeout=1 for that one cycle only if (c) caused the release and (a) and (b) were both false.
- Otherwise stay in GRANT and increment hold_cnt, saturating at its maximum.
- Handover always inserts exactly one dead cycle with gnt=0 between consecutive grants, including re-grants to the same requester.
- Fairness: the previous owner becomes lowest priority. If it is the only requester it is re-granted after the dead cycle.
- Requests that change while in GRANT do not affect the current owner. Only req[gnt_idx] is observed.
- done while gnt_valid=0 is ignored.
- req bits outside the owner may assert or deassert at any time. Arbitration uses the vector sampled in IDLE.
- Reset mid-grant: outputs drop asynchronously and the pointer returns to 7.
- Invariant: gnt is one-hot or zero, never multi-hot. gnt_valid==|gnt.

Test Plan:
- Reset, then req=8'b0000_0001 → gnt=8'h01, gnt_idx=0, gnt_valid=1 one cycle later. Drop req[0] → gnt=0 at the next edge.
- req=8'hFF held with done pulsed on the 3rd cycle of each grant → grant order 0,1,2,…,7,0. Each grant lasts 3 cycles, followed by one dead cycle.
- After owner 5 releases, req=8'b0010_0001 → next grant goes to 0 (wrap past 6,7). Then req=8'b0010_0000 → grant 5.
- MAX_HOLD=4, req[3] held with no done → gnt=8'h08 for exactly 4 cycles. Then timeout=1 for 1 cycle with gnt=0. Then gnt=8'h08 again.
- done and req[owner] drop together while hold_cnt==MAX_HOLD → release occurs, timeout stays 0.
- Assert rst mid-grant of requester 6 with req=8'hFF → outputs 0 immediately (asynchronous). After deassert, first grant goes to 0.
